// File: rtl/hamming_encoder_serializer_if.sv
// Bundle of the word handshake, the parallel codeword and the serial stream of the
// (7,4) Hamming transmitter.
interface hamming_encoder_serializer_if #(
    parameter int DATA_BITS    = 4,
    parameter int HAMMING_BITS = 7,
    parameter int CNT_WIDTH    = 16
);
    logic [DATA_BITS-1:0]    data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic                    err_inj;
    logic [2:0]              err_pos;
    logic [HAMMING_BITS-1:0] code_out;
    logic                    code_valid;
    logic                    tx_bit;
    logic                    tx_valid;
    logic                    tx_start;
    logic                    tx_last;
    logic [CNT_WIDTH-1:0]    frame_cnt;

    modport master (
        output data_in, data_valid, err_inj, err_pos,
        input  data_ready, code_out, code_valid, tx_bit, tx_valid, tx_start, tx_last, frame_cnt
    );

    modport slave (
        input  data_in, data_valid, err_inj, err_pos,
        output data_ready, code_out, code_valid, tx_bit, tx_valid, tx_start, tx_last, frame_cnt
    );
endinterface

// File: rtl/hamming_encoder_serializer.sv
// (7,4) Hamming encoder: registers the codeword (with optional single-bit error injection)
// and shifts it out MSB first with start/last frame markers and a saturating frame count.
//
// state    | meaning
// ST_IDLE  | waiting for a word, data_ready high
// ST_SHIFT | sending codeword bit bit_cnt (6 down to 0)
// ST_GAP   | idle cycles after the last bit, data_ready low
module hamming_encoder_serializer #(
    parameter int DATA_BITS    = 4,
    parameter int HAMMING_BITS = 7,
    parameter int CNT_WIDTH    = 16,
    parameter int IDLE_GAP     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    hamming_encoder_serializer_if.slave   bus
);
    localparam int GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int GAP_LOAD = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              bit_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [HAMMING_BITS-1:0] cw_reg;
    logic [HAMMING_BITS-1:0] cw_enc;
    logic [HAMMING_BITS-1:0] cw_inj;
    logic [DATA_BITS-1:0]    d;
    logic [CNT_WIDTH-1:0]    frame_cnt;
    logic                    code_valid_q;
    logic                    data_ready;
    logic                    last_bit;
    logic                    accept;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == 3'd0);
    assign accept   = bus.data_valid && data_ready;

    // Ready depends on state only; with no gap the last bit cycle may take the next word.
    always_comb begin
        data_ready = 1'b0;
        case (state)
            ST_IDLE:  data_ready = 1'b1;
            ST_SHIFT: data_ready = last_bit && (IDLE_GAP == 0);
            default:  data_ready = 1'b0;
        endcase
    end

    always_comb begin
        d      = bus.data_in;
        cw_enc = {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                  d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
        cw_inj = cw_enc;
        if (bus.err_inj && (bus.err_pos != 3'd7))
            cw_inj[bus.err_pos] = ~cw_enc[bus.err_pos];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == 3'd0) begin
                    if (IDLE_GAP == 0) state_nxt = accept ? ST_SHIFT : ST_IDLE;
                    else               state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= 3'd0;
            gap_cnt      <= '0;
            cw_reg       <= '0;
            code_valid_q <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            code_valid_q <= accept;
            if (accept) begin
                bit_cnt <= 3'd6;
                cw_reg  <= cw_inj;
            end else if ((state == ST_SHIFT) && (bit_cnt != 3'd0)) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
            // Gap timer loads on the last bit so GAP lasts exactly IDLE_GAP cycles.
            if (last_bit)
                gap_cnt <= GAP_W'(GAP_LOAD);
            else if ((state == ST_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
            if (last_bit && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.data_ready = data_ready;
        bus.code_out   = cw_reg;
        bus.code_valid = code_valid_q;
        bus.tx_valid   = (state == ST_SHIFT);
        bus.tx_bit     = (state == ST_SHIFT) && cw_reg[bit_cnt];
        bus.tx_start   = (state == ST_SHIFT) && (bit_cnt == 3'd6);
        bus.tx_last    = last_bit;
        bus.frame_cnt  = frame_cnt;
    end
endmodule

// File: tb/tb_hamming_encoder_serializer.sv
// Scoreboard bench: a generator-matrix model predicts codewords at issue time and a
// negedge monitor checks parallel output, serial frames, markers, gap and frame count.
module tb_hamming_encoder_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_encoder_serializer_if #(.DATA_BITS(4), .HAMMING_BITS(7), .CNT_WIDTH(16)) if0 ();
    hamming_encoder_serializer_if #(.DATA_BITS(4), .HAMMING_BITS(7), .CNT_WIDTH(2))  if1 ();

    hamming_encoder_serializer #(.DATA_BITS(4), .HAMMING_BITS(7), .CNT_WIDTH(16), .IDLE_GAP(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    hamming_encoder_serializer #(.DATA_BITS(4), .HAMMING_BITS(7), .CNT_WIDTH(2), .IDLE_GAP(2))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] cq0[$], sq0[$], cq1[$], sq1[$];
    int         bit_idx[2], gap_left[2], run_len[2], max_run[2], exp_cnt[2];
    logic       gap_end[2], cnt_pend[2];
    logic [6:0] shreg[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Codeword = XOR of generator rows for each set data bit, then optional bit flip.
    function automatic logic [6:0] model_cw(input logic [3:0] dw, input logic inj, input logic [2:0] pos);
        logic [6:0] rows [4];
        logic [6:0] cw;
        rows[0] = 7'b1101001;
        rows[1] = 7'b0101010;
        rows[2] = 7'b1001100;
        rows[3] = 7'b1110000;
        cw = '0;
        for (int i = 0; i < 4; i++) if (dw[i]) cw ^= rows[i];
        if (inj && pos < 3'd7) cw ^= (7'd1 << pos);
        return cw;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[6] ^ c[4] ^ c[2] ^ c[0], c[5] ^ c[4] ^ c[1] ^ c[0], c[3] ^ c[2] ^ c[1] ^ c[0]};
    endfunction

    task automatic mon(input int k, input logic rdy, input logic cv, input logic [6:0] co,
                       input logic txb, input logic tv, input logic ts, input logic tl, input int fc);
        logic [6:0] e;
        int         cmax;
        cmax = (k == 0) ? 65535 : 3;
        if (rst) begin
            bit_idx[k] = 0; gap_left[k] = 0; gap_end[k] = 0; cnt_pend[k] = 0;
            run_len[k] = 0; max_run[k] = 0; exp_cnt[k] = 0; shreg[k] = '0;
            if (k == 0) begin cq0.delete(); sq0.delete(); end
            else        begin cq1.delete(); sq1.delete(); end
            return;
        end
        if (cnt_pend[k]) begin
            check($sformatf("frame_cnt%0d", k), fc, exp_cnt[k]);
            cnt_pend[k] = 0;
        end
        if (gap_left[k] > 0) begin
            check($sformatf("gap_ready%0d", k), rdy, 0);
            check($sformatf("gap_txvalid%0d", k), tv, 0);
            gap_left[k]--;
            if (gap_left[k] == 0) gap_end[k] = 1;
        end else if (gap_end[k]) begin
            check($sformatf("post_gap_ready%0d", k), rdy, 1);
            gap_end[k] = 0;
        end
        check($sformatf("start_align%0d", k), ts, cv);
        if (cv) begin
            if ((k == 0 && cq0.size() == 0) || (k == 1 && cq1.size() == 0)) begin
                timeout_fail($sformatf("code_unexpected%0d", k));
            end else begin
                if (k == 0) e = cq0.pop_front();
                else        e = cq1.pop_front();
                check($sformatf("code_out%0d", k), co, e);
            end
        end
        if (tv) begin
            run_len[k]++;
            if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
            check($sformatf("tx_start%0d", k), ts, bit_idx[k] == 0);
            check($sformatf("tx_last%0d", k), tl, bit_idx[k] == 6);
            shreg[k] = {shreg[k][5:0], txb};
            bit_idx[k]++;
            if (bit_idx[k] == 7) begin
                bit_idx[k] = 0;
                if ((k == 0 && sq0.size() == 0) || (k == 1 && sq1.size() == 0)) begin
                    timeout_fail($sformatf("frame_unexpected%0d", k));
                end else begin
                    if (k == 0) e = sq0.pop_front();
                    else        e = sq1.pop_front();
                    check($sformatf("serial_frame%0d", k), shreg[k], e);
                end
                if (exp_cnt[k] < cmax) exp_cnt[k]++;
                cnt_pend[k] = 1;
                gap_left[k] = (k == 0) ? 0 : 2;
            end
        end else begin
            run_len[k] = 0;
            check($sformatf("idle_markers%0d", k), {ts, tl}, 2'b00);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.data_ready, if0.code_valid, if0.code_out, if0.tx_bit, if0.tx_valid,
            if0.tx_start, if0.tx_last, int'(if0.frame_cnt));
        mon(1, if1.data_ready, if1.code_valid, if1.code_out, if1.tx_bit, if1.tx_valid,
            if1.tx_start, if1.tx_last, int'(if1.frame_cnt));
    end

    task automatic drive(input int k, input logic v, input logic [3:0] dw, input logic inj, input logic [2:0] pos);
        if (k == 0) begin
            if0.data_valid = v; if0.data_in = dw; if0.err_inj = inj; if0.err_pos = pos;
        end else begin
            if1.data_valid = v; if1.data_in = dw; if1.err_inj = inj; if1.err_pos = pos;
        end
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 4'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic send(input int k, input logic [3:0] dw, input logic inj, input logic [2:0] pos);
        logic       rdy;
        logic       done;
        logic [6:0] e;
        done = 0;
        drive(k, 1'b1, dw, inj, pos);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            rdy = (k == 0) ? if0.data_ready : if1.data_ready;
            if (rdy) begin
                e = model_cw(dw, inj, pos);
                if (k == 0) begin cq0.push_back(e); sq0.push_back(e); end
                else        begin cq1.push_back(e); sq1.push_back(e); end
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) timeout_fail($sformatf("send_timeout%0d", k));
    endtask

    task automatic wait_idle(input int k);
        logic done;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (k == 0) done = if0.data_ready && !if0.tx_valid && sq0.size() == 0 && cq0.size() == 0;
            else        done = if1.data_ready && !if1.tx_valid && sq1.size() == 0 && cq1.size() == 0;
        end
        if (!done) timeout_fail($sformatf("idle_timeout%0d", k));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input int k);
        if (k == 0) begin
            check("rst_ready0", if0.data_ready, 1);
            check("rst_outs0", {if0.code_out, if0.code_valid, if0.tx_bit, if0.tx_valid,
                                if0.tx_start, if0.tx_last}, 0);
            check("rst_cnt0", if0.frame_cnt, 0);
        end else begin
            check("rst_ready1", if1.data_ready, 1);
            check("rst_outs1", {if1.code_out, if1.code_valid, if1.tx_bit, if1.tx_valid,
                                if1.tx_start, if1.tx_last}, 0);
            check("rst_cnt1", if1.frame_cnt, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(0);
        idle(1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst = 1'b0;

        // Single word, known codeword
        send(0, 4'b1011, 1'b0, 3'd0);
        idle(0);
        wait_idle(0);
        check("known_cw_1011", if0.code_out, 7'b0110011);
        check("cnt_after_one", if0.frame_cnt, 1);

        // Back-to-back frames with valid held
        do_reset();
        send(0, 4'b0001, 1'b0, 3'd0);
        send(0, 4'b1111, 1'b0, 3'd0);
        idle(0);
        wait_idle(0);
        check("b2b_cnt", if0.frame_cnt, 2);
        check("b2b_run", max_run[0], 14);

        // Error injection
        send(0, 4'b0000, 1'b1, 3'd2);
        idle(0);
        wait_idle(0);
        check("inj_pos2", if0.code_out, 7'b0000100);
        check("inj_syndrome", syndrome(if0.code_out) != 3'd0, 1);
        send(0, 4'b0000, 1'b1, 3'd7);
        idle(0);
        wait_idle(0);
        check("inj_pos7", if0.code_out, 7'b0000000);
        check("clean_syndrome", syndrome(if0.code_out), 0);

        // Reset in the middle of a frame
        do_reset();
        send(0, 4'b1111, 1'b0, 3'd0);
        idle(0);
        repeat (3) begin @(posedge clk); #1; end
        check("midframe_active", if0.tx_valid, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals(0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 4'b1111, 1'b0, 3'd0);
        idle(0);
        wait_idle(0);
        check("post_rst_cw", if0.code_out, 7'b1111111);
        check("post_rst_cnt", if0.frame_cnt, 1);

        // Gap of two cycles and 2-bit saturating counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1, 4'($urandom), 1'b0, 3'd0);
            idle(1);
            wait_idle(1);
            check($sformatf("sat_cnt_%0d", i), if1.frame_cnt, (i < 3) ? i + 1 : 3);
        end

        // Randomized traffic on both instances
        do_reset();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g0;
                    g0 = $urandom_range(0, 2);
                    if (g0 > 0) begin
                        idle(0);
                        repeat (g0) begin @(posedge clk); #1; end
                    end
                    send(0, 4'($urandom), $urandom_range(0, 3) == 0, 3'($urandom));
                end
                idle(0);
                wait_idle(0);
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    int g1;
                    g1 = $urandom_range(0, 2);
                    if (g1 > 0) begin
                        idle(1);
                        repeat (g1) begin @(posedge clk); #1; end
                    end
                    send(1, 4'($urandom), $urandom_range(0, 3) == 0, 3'($urandom));
                end
                idle(1);
                wait_idle(1);
            end
        join
        check("rand_cnt0", if0.frame_cnt, 40);
        check("rand_cnt1", if1.frame_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
